// File: rtl/ssd_scan_if.sv
// Seven-segment scan receive bus: multiplexed select/segment inputs
// and the decoded digit bank with its status pulses and error count.
interface ssd_scan_if #(
   parameter int DIGITS = 4
);
   logic [DIGITS-1:0]   an;
   logic [6:0]          seg;
   logic [4*DIGITS-1:0] digits;
   logic [DIGITS-1:0]   digit_valid;
   logic                upd;
   logic                err;
   logic [7:0]          err_cnt;

   modport master (
      output an, seg,
      input  digits, digit_valid, upd, err, err_cnt
   );

   modport slave (
      input  an, seg,
      output digits, digit_valid, upd, err, err_cnt
   );
endinterface

// File: rtl/ssd_scan_decoder.sv
// Seven-segment scan decoder: recovers hex digits from an active-low
// multiplexed display bus once a {an, seg} sample has been stable.
// Ports: clk, rst (sync, active high), bus (ssd_scan_if.slave):
//   an/seg in; digits, digit_valid, upd, err, err_cnt out.
// Option: define SSD_SCAN_ALT_GLYPH_EN to accept 7'h58 (7) and 7'h18 (9).
module ssd_scan_decoder #(
   parameter int DIGITS = 4,
   parameter int STABLE = 4
) (
   input  logic     clk,
   input  logic     rst,
   ssd_scan_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      DONE
   } state_e;

   // cnt counts repeats after the first sample, so STABLE identical
   // samples are reached when cnt hits STABLE-1.
   localparam logic [7:0] CNT_LAST = 8'(STABLE - 1);

   logic [DIGITS-1:0]   s_an_q, s_an_d;
   logic [6:0]          s_seg_q, s_seg_d;
   logic [7:0]          cnt_q, cnt_d;
   state_e              state_q, state_d;
   logic [4*DIGITS-1:0] digits_q, digits_d;
   logic [DIGITS-1:0]   valid_q, valid_d;
   logic                upd_q, upd_d;
   logic                err_q, err_d;
   logic [7:0]          err_cnt_q, err_cnt_d;

   logic       same;
   logic       sel_ok;
   logic       commit;
   logic [4:0] glyph;

   // Returns {legal, value}.
   function automatic logic [4:0] decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h40:   r = {1'b1, 4'h0};
         7'h79:   r = {1'b1, 4'h1};
         7'h24:   r = {1'b1, 4'h2};
         7'h30:   r = {1'b1, 4'h3};
         7'h19:   r = {1'b1, 4'h4};
         7'h12:   r = {1'b1, 4'h5};
         7'h02:   r = {1'b1, 4'h6};
         7'h78:   r = {1'b1, 4'h7};
         7'h00:   r = {1'b1, 4'h8};
         7'h10:   r = {1'b1, 4'h9};
         7'h08:   r = {1'b1, 4'hA};
         7'h03:   r = {1'b1, 4'hB};
         7'h46:   r = {1'b1, 4'hC};
         7'h21:   r = {1'b1, 4'hD};
         7'h06:   r = {1'b1, 4'hE};
         7'h0E:   r = {1'b1, 4'hF};
`ifdef SSD_SCAN_ALT_GLYPH_EN
         7'h58:   r = {1'b1, 4'h7};
         7'h18:   r = {1'b1, 4'h9};
`endif
         default: r = 5'b0;
      endcase
      return r;
   endfunction

   always_comb begin
      s_an_d  = bus.an;
      s_seg_d = bus.seg;
      same    = ({bus.an, bus.seg} == {s_an_q, s_seg_q});
      sel_ok  = $onehot(~s_an_q);
      glyph   = decode(s_seg_q);

      cnt_d = 8'd0;
      if (same) begin
         cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      end

      state_d = state_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_ok) begin
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (!sel_ok) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               commit  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            // cnt_q == 0 marks the first sample of a new pattern.
            if (cnt_q == 8'd0) begin
               state_d = sel_ok ? COUNT : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      digits_d  = digits_q;
      valid_d   = valid_q;
      upd_d     = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      if (commit) begin
         if (s_seg_q == 7'h7F) begin
            upd_d = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
               if (!s_an_q[i]) begin
                  valid_d[i] = 1'b0;
               end
            end
         end else if (glyph[4]) begin
            upd_d = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
               if (!s_an_q[i]) begin
                  digits_d[4*i +: 4] = glyph[3:0];
                  valid_d[i]         = 1'b1;
               end
            end
         end else begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
               err_cnt_d = err_cnt_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_an_q    <= '1;
         s_seg_q   <= 7'h7F;
         cnt_q     <= 8'd0;
         state_q   <= IDLE;
         digits_q  <= '0;
         valid_q   <= '0;
         upd_q     <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         s_an_q    <= s_an_d;
         s_seg_q   <= s_seg_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         digits_q  <= digits_d;
         valid_q   <= valid_d;
         upd_q     <= upd_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.digits      = digits_q;
   assign bus.digit_valid = valid_q;
   assign bus.upd         = upd_q;
   assign bus.err         = err_q;
   assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder (DIGITS=4, STABLE=4): vector
// table plus hand sequences for latency, glitching and mid-run reset.
module tb_ssd_scan_decoder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   ssd_scan_if #(.DIGITS(4)) bus ();

   ssd_scan_decoder #(
      .DIGITS(4),
      .STABLE(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      int          hold;
      logic [15:0] e_dig;
      logic [3:0]  e_val;
      int          e_upd;
      int          e_err;
      logic [7:0]  e_ecnt;
   } vec_t;

   vec_t v[11];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n, output int nu, output int ne);
      nu = 0;
      ne = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         chk("upd_err_excl", {31'd0, bus.upd & bus.err}, 32'd0);
         if (bus.upd) nu++;
         if (bus.err) ne++;
      end
   endtask

   initial begin
      int nu, ne;

      v[0]  = '{4'hE, 7'h79, 6, 16'h0001, 4'b0001, 1, 0, 8'd0};
      v[1]  = '{4'hD, 7'h0E, 6, 16'h00F1, 4'b0011, 1, 0, 8'd0};
      v[2]  = '{4'hB, 7'h46, 6, 16'h0CF1, 4'b0111, 1, 0, 8'd0};
      v[3]  = '{4'h7, 7'h00, 6, 16'h8CF1, 4'b1111, 1, 0, 8'd0};
      v[4]  = '{4'hB, 7'h55, 8, 16'h8CF1, 4'b1111, 0, 1, 8'd1};
      v[5]  = '{4'hB, 7'h7F, 8, 16'h8CF1, 4'b1011, 1, 0, 8'd1};
      v[6]  = '{4'hC, 7'h40, 10, 16'h8CF1, 4'b1011, 0, 0, 8'd1};
`ifdef SSD_SCAN_ALT_GLYPH_EN
      v[7]  = '{4'hE, 7'h58, 8, 16'h8CF7, 4'b1011, 1, 0, 8'd1};
      v[8]  = '{4'hF, 7'h7F, 5, 16'h8CF7, 4'b1011, 0, 0, 8'd1};
      v[9]  = '{4'hE, 7'h12, 8, 16'h8CF5, 4'b1011, 1, 0, 8'd1};
      v[10] = '{4'hE, 7'h18, 8, 16'h8CF9, 4'b1011, 1, 0, 8'd1};
`else
      v[7]  = '{4'hE, 7'h58, 8, 16'h8CF1, 4'b1011, 0, 1, 8'd2};
      v[8]  = '{4'hF, 7'h7F, 5, 16'h8CF1, 4'b1011, 0, 0, 8'd2};
      v[9]  = '{4'hE, 7'h12, 8, 16'h8CF5, 4'b1011, 1, 0, 8'd2};
      v[10] = '{4'hE, 7'h18, 8, 16'h8CF5, 4'b1011, 0, 1, 8'd3};
`endif

      bus.an  = 4'hF;
      bus.seg = 7'h7F;
      rst = 1'b1;
      tick();
      tick();
      chk("rst_digits", {16'd0, bus.digits}, 32'd0);
      chk("rst_valid", {28'd0, bus.digit_valid}, 32'd0);
      chk("rst_upd", {31'd0, bus.upd}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk("rst_ecnt", {24'd0, bus.err_cnt}, 32'd0);
      rst = 1'b0;

      // Latency: upd exactly on the 5th edge after inputs settle.
      bus.an  = 4'hE;
      bus.seg = 7'h24;
      for (int t = 1; t <= 10; t++) begin
         tick();
         chk("lat_upd", {31'd0, bus.upd}, (t == 5) ? 32'd1 : 32'd0);
         chk("lat_err", {31'd0, bus.err}, 32'd0);
      end
      chk("lat_digits", {16'd0, bus.digits}, 32'h0002);
      chk("lat_valid", {28'd0, bus.digit_valid}, 32'b0001);

      // Pattern flips every 2 cycles never becomes stable.
      for (int k = 0; k < 10; k++) begin
         bus.seg = (k % 2 == 0) ? 7'h30 : 7'h24;
         run(2, nu, ne);
         chk("alt_upd", nu, 0);
         chk("alt_err", ne, 0);
      end
      chk("alt_digits", {16'd0, bus.digits}, 32'h0002);

      for (int r = 0; r < 11; r++) begin
         bus.an  = v[r].an;
         bus.seg = v[r].seg;
         run(v[r].hold, nu, ne);
         chk($sformatf("v%0d_digits", r), {16'd0, bus.digits},
             {16'd0, v[r].e_dig});
         chk($sformatf("v%0d_valid", r), {28'd0, bus.digit_valid},
             {28'd0, v[r].e_val});
         chk($sformatf("v%0d_upd", r), nu, v[r].e_upd);
         chk($sformatf("v%0d_err", r), ne, v[r].e_err);
         chk($sformatf("v%0d_ecnt", r), {24'd0, bus.err_cnt},
             {24'd0, v[r].e_ecnt});
      end

      // Reset one edge before the commit would land.
      bus.an  = 4'hD;
      bus.seg = 7'h12;
      run(3, nu, ne);
      chk("mr_pre_upd", nu, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.an  = 4'hF;
      bus.seg = 7'h7F;
      chk("mr_digits", {16'd0, bus.digits}, 32'd0);
      chk("mr_valid", {28'd0, bus.digit_valid}, 32'd0);
      chk("mr_upd", {31'd0, bus.upd}, 32'd0);
      chk("mr_ecnt", {24'd0, bus.err_cnt}, 32'd0);
      run(8, nu, ne);
      chk("mr_post_upd", nu, 0);
      chk("mr_post_err", ne, 0);
      chk("mr_post_digits", {16'd0, bus.digits}, 32'd0);
      chk("mr_post_valid", {28'd0, bus.digit_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
